// File: rtl/rand_key_collector.sv
// rand_key_collector: assembles KEY_BYTES random bytes into one private-key
// candidate, rejects invalid candidates and re-collects, then holds the
// accepted key under a valid/ack handshake.
// Optional macro KEY_RANGE_CHECK_EN: also reject keys >= secp256k1 order n.
//
// state   | meaning
// IDLE    | waiting for i_start
// COLLECT | accepting bytes from the random generator
// CHECK   | one-cycle validity check of the assembled candidate
// DONE    | key held with o_key_valid until i_key_ack
`timescale 1ns/1ps
module rand_key_collector #(
    parameter int KEY_BYTES = 32,
    parameter int SKIP      = 0
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [7:0]             i_rand_data,
    input  logic                   i_rand_valid,
    input  logic                   i_start,
    input  logic                   i_key_ack,
    output logic [8*KEY_BYTES-1:0] o_key,
    output logic                   o_key_valid,
    output logic                   o_busy,
    output logic [7:0]             o_retry_cnt
);
    localparam int KW = 8 * KEY_BYTES;
    localparam int CW = $clog2(KEY_BYTES + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(KEY_BYTES - 1);
    localparam logic [3:0]    SKIP_LD  = 4'(SKIP);

    typedef enum logic [1:0] {IDLE, COLLECT, CHECK, DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] byte_cnt;
    logic [3:0]    skip_cnt;
    logic          accept;
    logic          last_byte;
    logic          key_bad;

    assign accept    = (state == COLLECT) && i_rand_valid && (skip_cnt == 4'd0);
    assign last_byte = accept && (byte_cnt == LAST_IDX);

`ifdef KEY_RANGE_CHECK_EN
    localparam logic [255:0] GROUP_ORDER =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;

    if (KEY_BYTES != 32) begin : g_key_bytes_check
        $error("rand_key_collector: KEY_RANGE_CHECK_EN requires KEY_BYTES=32");
    end

    assign key_bad = (o_key == '0) || (o_key >= KW'(GROUP_ORDER));
`else
    assign key_bad = (o_key == '0);
`endif

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start)   state_next = COLLECT;
            COLLECT: if (last_byte) state_next = CHECK;
            CHECK:   state_next = key_bad ? COLLECT : DONE;
            DONE:    if (i_key_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; o_busy registered from the next state so it tracks state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state  <= IDLE;
            o_busy <= 1'b0;
        end else begin
            state  <= state_next;
            o_busy <= (state_next == COLLECT) || (state_next == CHECK);
        end
    end

    // Key assembly, counters and handshake flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_key       <= '0;
            o_key_valid <= 1'b0;
            o_retry_cnt <= 8'd0;
            byte_cnt    <= '0;
            skip_cnt    <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_key       <= '0;
                        o_retry_cnt <= 8'd0;
                        byte_cnt    <= '0;
                        skip_cnt    <= 4'd0;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        o_key    <= {o_key[KW-9:0], i_rand_data};
                        byte_cnt <= byte_cnt + 1'b1;
                        skip_cnt <= SKIP_LD;
                    end else if (i_rand_valid) begin
                        skip_cnt <= skip_cnt - 4'd1;
                    end
                end
                CHECK: begin
                    if (key_bad) begin
                        o_key    <= '0;
                        byte_cnt <= '0;
                        skip_cnt <= 4'd0;
                        if (o_retry_cnt != 8'hFF) o_retry_cnt <= o_retry_cnt + 8'd1;
                    end else begin
                        o_key_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (i_key_ack) o_key_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rand_key_collector.sv
// Testbench for rand_key_collector: two instances (SKIP=0 and SKIP=2) sharing
// the random byte stream, checked against a cycle-level behavioural model
// plus directed expectations.
`timescale 1ns/1ps
module tb_rand_key_collector;
    localparam int M_IDLE = 0, M_COLLECT = 1, M_CHECK = 2, M_DONE = 3;
    localparam int SKIPV [2] = '{0, 2};
`ifdef KEY_RANGE_CHECK_EN
    localparam logic [255:0] ORDER_N =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;
`endif

    logic         clk;
    logic [7:0]   data;
    logic         valid;
    logic         rst   [2];
    logic         start [2];
    logic         ack   [2];
    logic [255:0] okey  [2];
    logic         okv   [2];
    logic         obusy [2];
    logic [7:0]   oretry[2];

    int           vectors = 0;
    int           miscompares = 0;
    int           cnt = 0;

    int           m_mode [2];
    int           m_n    [2];
    int           m_skip [2];
    int           m_retry[2];
    logic [255:0] m_key  [2];
    bit           m_kv   [2];

    rand_key_collector #(.KEY_BYTES(32), .SKIP(0)) dut0 (
        .i_clk(clk), .i_reset(rst[0]), .i_rand_data(data), .i_rand_valid(valid),
        .i_start(start[0]), .i_key_ack(ack[0]), .o_key(okey[0]),
        .o_key_valid(okv[0]), .o_busy(obusy[0]), .o_retry_cnt(oretry[0]));

    rand_key_collector #(.KEY_BYTES(32), .SKIP(2)) dut1 (
        .i_clk(clk), .i_reset(rst[1]), .i_rand_data(data), .i_rand_valid(valid),
        .i_start(start[1]), .i_key_ack(ack[1]), .o_key(okey[1]),
        .o_key_valid(okv[1]), .o_busy(obusy[1]), .o_retry_cnt(oretry[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit model_bad(input logic [255:0] k);
`ifdef KEY_RANGE_CHECK_EN
        return (k == 0) || (k >= ORDER_N);
`else
        return (k == 0);
`endif
    endfunction

    task automatic model_step(input int k);
        if (rst[k]) begin
            m_mode[k] = M_IDLE; m_n[k] = 0; m_skip[k] = 0;
            m_retry[k] = 0; m_key[k] = 0; m_kv[k] = 0;
        end else begin
            case (m_mode[k])
                M_IDLE: if (start[k]) begin
                    m_mode[k] = M_COLLECT; m_n[k] = 0; m_skip[k] = 0;
                    m_retry[k] = 0; m_key[k] = 0;
                end
                M_COLLECT: if (valid) begin
                    if (m_skip[k] == 0) begin
                        m_key[k] = (m_key[k] << 8) | 256'(data);
                        m_n[k]++;
                        m_skip[k] = SKIPV[k];
                        if (m_n[k] == 32) m_mode[k] = M_CHECK;
                    end else begin
                        m_skip[k]--;
                    end
                end
                M_CHECK: if (model_bad(m_key[k])) begin
                    m_mode[k] = M_COLLECT; m_n[k] = 0; m_skip[k] = 0; m_key[k] = 0;
                    if (m_retry[k] < 255) m_retry[k]++;
                end else begin
                    m_mode[k] = M_DONE; m_kv[k] = 1;
                end
                default: if (ack[k]) begin
                    m_mode[k] = M_IDLE; m_kv[k] = 0;
                end
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k);
        cnt++;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("key%0d", k), okey[k], m_key[k]);
            chk($sformatf("valid%0d", k), 256'(okv[k]), 256'(m_kv[k]));
            chk($sformatf("busy%0d", k), 256'(obusy[k]),
                256'(m_mode[k] == M_COLLECT || m_mode[k] == M_CHECK));
            chk($sformatf("retry%0d", k), 256'(oretry[k]), 256'(m_retry[k]));
        end
    endtask

    logic [255:0] exp_key;
    int           s;
    int           v;

    initial begin
        data = 8'h00; valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; start[k] = 1'b0; ack[k] = 1'b0;
            m_mode[k] = M_IDLE; m_n[k] = 0; m_skip[k] = 0;
            m_retry[k] = 0; m_key[k] = 0; m_kv[k] = 0;
        end
        tick(); tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_key", okey[k], 256'd0);
            chk("rst_valid", 256'(okv[k]), 256'd0);
            chk("rst_busy", 256'(obusy[k]), 256'd0);
            chk("rst_retry", 256'(oretry[k]), 256'd0);
            rst[k] = 1'b0;
        end
        tick();

        // Incrementing bytes 0x01..0x20, then DONE hold and ack.
        start[0] = 1'b1; tick(); start[0] = 1'b0; s = cnt;
        exp_key = '0;
        for (int i = 1; i <= 32; i++) begin
            data = 8'(i); tick();
            exp_key = (exp_key << 8) | 256'(i);
            if (i == 1) chk("s1_busy", 256'(obusy[0]), 256'd1);
        end
        data = 8'h77; tick();
        chk("s1_valid", 256'(okv[0]), 256'd1);
        chk("s1_latency", 256'(cnt - s), 256'd33);
        chk("s1_key", okey[0], exp_key);
        chk("s1_retry", 256'(oretry[0]), 256'd0);
        for (int i = 0; i < 6; i++) begin
            data = 8'($urandom); start[0] = (i == 2); tick();
            chk("done_hold", okey[0], exp_key);
            chk("done_valid", 256'(okv[0]), 256'd1);
        end
        start[0] = 1'b1; ack[0] = 1'b1; tick(); start[0] = 1'b0; ack[0] = 1'b0;
        chk("ack_valid", 256'(okv[0]), 256'd0);
        chk("ack_key_kept", okey[0], exp_key);
        tick();
        chk("ack_idle_busy", 256'(obusy[0]), 256'd0);

        // 32 zero bytes rejected, then 32 x 0x5A accepted.
        start[0] = 1'b1; tick(); start[0] = 1'b0; s = cnt;
        data = 8'h00;
        for (int i = 0; i < 32; i++) tick();
        data = 8'h5A;
        v = 0;
        while (!okv[0] && v < 200) begin tick(); v++; end
        chk("s2_latency", 256'(cnt - s), 256'd66);
        chk("s2_retry", 256'(oretry[0]), 256'd1);
        chk("s2_key", okey[0], {32{8'h5A}});
        ack[0] = 1'b1; tick(); ack[0] = 1'b0;

        // All-ones candidate.
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        data = 8'hFF;
        for (int i = 0; i < 32; i++) tick();
        tick();
`ifdef KEY_RANGE_CHECK_EN
        chk("s3_rejected", 256'(okv[0]), 256'd0);
        chk("s3_retry", 256'(oretry[0]), 256'd1);
        chk("s3_busy", 256'(obusy[0]), 256'd1);
        data = 8'h11;
        v = 0;
        while (!okv[0] && v < 200) begin tick(); v++; end
        chk("s3_key", okey[0], {32{8'h11}});
`else
        chk("s3_valid", 256'(okv[0]), 256'd1);
        chk("s3_key", okey[0], {32{8'hFF}});
        chk("s3_retry", 256'(oretry[0]), 256'd0);
`endif
        ack[0] = 1'b1; tick(); ack[0] = 1'b0;

        // SKIP=2 instance, stream incrementing every cycle from 0x00.
        start[1] = 1'b1; data = 8'h00; tick(); start[1] = 1'b0; s = cnt;
        v = 0;
        while (!okv[1] && v < 300) begin data = 8'(v); tick(); v++; end
        exp_key = '0;
        for (int j = 0; j < 32; j++) exp_key = (exp_key << 8) | 256'(3 * j);
        chk("s4_latency", 256'(cnt - s), 256'(1 + 31 * 3 + 1));
        chk("s4_key", okey[1], exp_key);
        ack[1] = 1'b1; tick(); ack[1] = 1'b0;

        // Reset mid-collection, then a clean key with stalls and ignored pulses.
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin data = 8'($urandom); tick(); end
        rst[0] = 1'b1; tick(); rst[0] = 1'b0;
        chk("s5_busy", 256'(obusy[0]), 256'd0);
        chk("s5_key", okey[0], 256'd0);
        chk("s5_valid", 256'(okv[0]), 256'd0);
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        exp_key = '0;
        for (int i = 0; i < 32; i++) begin
            if (i == 5) begin valid = 1'b0; data = 8'hFF; tick(); tick(); valid = 1'b1; end
            data = 8'(8'hA0 + i);
            start[0] = (i == 10); ack[0] = (i == 15);
            tick();
            start[0] = 1'b0; ack[0] = 1'b0;
            exp_key = (exp_key << 8) | 256'(8'hA0 + i);
            if (i == 15) chk("s5_ack_ignored", 256'(obusy[0]), 256'd1);
        end
        tick();
        chk("s5_valid_final", 256'(okv[0]), 256'd1);
        chk("s5_key_final", okey[0], exp_key);
        ack[0] = 1'b1; tick(); ack[0] = 1'b0;

        // Retry counter saturation with a constant zero stream.
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        data = 8'h00;
        for (int i = 0; i < 260 * 33; i++) tick();
        chk("sat_retry", 256'(oretry[0]), 256'd255);
        chk("sat_busy", 256'(obusy[0]), 256'd1);
        rst[0] = 1'b1; tick(); rst[0] = 1'b0;

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            data  = 8'($urandom);
            valid = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 2; k++) begin
                rst[k]   = ($urandom_range(0, 299) == 0);
                start[k] = ($urandom_range(0, 7) == 0);
                ack[k]   = ($urandom_range(0, 3) == 0);
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
